iter_controller: RTL and testbench
==================================

# iter_controller

Parametrised sequencing controller for the iterative neuron datapath (weight/input registers, multiplier, accumulator, activation register). It runs a start-handshaked multiply-accumulate pass over N_IN terms per iteration, writes back the activation, and repeats until the datapath raises isfinished or an iteration budget runs out. It replaces the fixed single-term controller. New features are a term index counter, an iteration counter with timeout, abort, and busy/status outputs.

## Interface
- N_IN, 4, terms accumulated per iteration; must be ≥1
- MAX_ITER, 16, iteration budget before forced termination; must be ≥1
- IDX_W, max(1,$clog2(N_IN)), derived width of idx
- ITER_W, $clog2(MAX_ITER+1), derived width of iter
- clk  in  1  single clock, all state updates on posedge
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on posedge clk)
- start  in  1  level request; run begins when start is released after being seen high
- isfinished  in  1  datapath convergence flag, sampled only in CHECK
- abort  in  1  cancels the run from any non-IDLE state
- init_w, init_x  out  1  load weight/input registers (INIT only)
- load_sel  out  1  1 = select external initial values into activation register
- load_a  out  1  activation register write enable
- acc_clr  out  1  clear accumulator (MULT with idx==0)
- mult_en  out  1  multiplier operand capture (MULT)
- acc_en  out  1  accumulator add enable (ADD)
- idx  out  IDX_W  current term index, selects operand mux
- iter  out  ITER_W  completed-iteration count
- busy  out  1  high in every state except IDLE
- timeout  out  1  sticky: last run ended by budget, not isfinished
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, INIT, MULT, ADD, WB_ACT, CHECK, DONE.
- Outputs are Moore decodes of the state register and counters. No extra output registers.
- IDLE: idle until start=1. Then go to INIT.
- INIT: init_w=init_x=load_a=load_sel=1. Clear idx, iter and timeout. Stay while start=1. On start=0, go to MULT.
- MULT: mult_en=1; acc_clr=1 iff idx==0. Go to ADD.
- ADD: acc_en=1.
  - If idx==N_IN-1: clear idx, go to WB_ACT.
  - Otherwise: increment idx, go to MULT.
- WB_ACT: load_a=1, load_sel=0. Go to CHECK.
- CHECK: iter increments on every exit.
  - isfinished=1: go to DONE with timeout=0.
  - Else if iter==MAX_ITER-1: go to DONE with timeout=1.
  - Else: go to MULT.
- DONE: done=1 for exactly one cycle. Go to IDLE. iter and timeout hold until the next INIT.
- abort=1 in any non-IDLE state: go to IDLE on the next edge.
  - No done pulse. idx cleared. iter and timeout hold.
  - Abort takes priority over all other transitions.
- Reset has priority over abort and start.
- isfinished and budget exhaustion on the same CHECK: isfinished wins, timeout=0.
- start asserted in MULT..DONE is ignored. A new run requires returning to IDLE.
- Unused state encodings go to IDLE.

## Timing
- Reset (rst=0 at posedge): state IDLE. idx=0, iter=0. init_w=init_x=load_a=load_sel=acc_clr=mult_en=acc_en=busy=timeout=done=0.
- Reset mid-run: same result. Takes effect on the sampled edge.
- IDLE→INIT takes 1 edge after start=1 is sampled. INIT lasts ≥1 cycle.
- One iteration lasts 2·N_IN+2 cycles: N_IN MULT/ADD pairs, then WB_ACT, then CHECK.
- Count cycles from the first MULT cycle (cycle 0). With k iterations, DONE is the cycle at index k·(2·N_IN+2).
- The done pulse is the cycle before IDLE. busy falls on the same edge that done falls.
- iter counts up to a maximum of MAX_ITER and never wraps.
- idx sequence per iteration is 0..N_IN-1. With N_IN=1, idx is constantly 0 and acc_clr is high on every MULT.

## Test plan
- Reset and basic run (N_IN=4, MAX_ITER=8):
  - Stimulus: rst=0 for 2 cycles, then start high 3 cycles then low; isfinished=1 at the first CHECK.
  - Required: all outputs 0 during reset; INIT held 3 cycles with init_w/init_x/load_a/load_sel=1; idx 0,0,1,1,2,2,3,3 over the MULT/ADD cycles; load_a at cycle 8; done at cycle 10; iter=1; timeout=0.
- Convergence at iteration 3:
  - Stimulus: isfinished=1 only at the third CHECK.
  - Required: done at cycle 30, iter=3, acc_clr pulses at cycles 0, 10 and 20.
- Timeout:
  - Stimulus: isfinished held 0.
  - Required: done at cycle 80, iter=8, timeout=1. timeout stays 1 in IDLE and clears in the next INIT.
- Tie:
  - Stimulus: isfinished=1 on the 8th CHECK.
  - Required: done, iter=8, timeout=0.
- Abort and reset mid-run:
  - Stimulus: abort=1 in the ADD cycle with idx=2 of iteration 2.
  - Required: IDLE next cycle, no done, idx=0, iter=1. A new start then runs normally.
  - Stimulus: separately, rst=0 during WB_ACT.
  - Required: reset values on the next edge.
- Parameter corner (N_IN=1, MAX_ITER=1):
  - Stimulus: isfinished=0.
  - Required: sequence MULT, ADD, WB_ACT, CHECK, DONE; done at cycle 4; iter=1; timeout=1.

Source files
------------

// File: rtl/iter_controller.sv
// Sequencing controller for the iterative neuron datapath: runs N_IN multiply/add
// pairs per iteration, writes back the activation, and repeats until convergence or budget.
module iter_controller #(
  parameter int N_IN     = 4,
  parameter int MAX_ITER = 16,
  parameter int IDX_W    = (N_IN > 1) ? $clog2(N_IN) : 1,
  parameter int ITER_W   = $clog2(MAX_ITER + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              isfinished,
  input  logic              abort,
  output logic              init_w,
  output logic              init_x,
  output logic              load_sel,
  output logic              load_a,
  output logic              acc_clr,
  output logic              mult_en,
  output logic              acc_en,
  output logic [IDX_W-1:0]  idx,
  output logic [ITER_W-1:0] iter,
  output logic              busy,
  output logic              timeout,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    MULT   = 3'd2,
    ADD    = 3'd3,
    WB_ACT = 3'd4,
    CHECK  = 3'd5,
    DONE   = 3'd6
  } state_t;

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_IN - 1);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(MAX_ITER - 1);
  localparam logic [ITER_W-1:0] ITER_MAX  = ITER_W'(MAX_ITER);

  state_t state;
  state_t state_nxt;
  logic   aborting;

  assign aborting = abort && (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    if (!aborting) begin
      case (state)
        IDLE:    state_nxt = start ? INIT : IDLE;
        INIT:    state_nxt = start ? INIT : MULT;
        MULT:    state_nxt = ADD;
        ADD:     state_nxt = (idx == IDX_LAST) ? WB_ACT : MULT;
        WB_ACT:  state_nxt = CHECK;
        CHECK:   state_nxt = (isfinished || (iter == ITER_LAST)) ? DONE : MULT;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Counters are cleared on the edge into INIT so the first INIT cycle already shows a fresh run.
  always_ff @(posedge clk) begin
    if (!rst) begin
      idx     <= '0;
      iter    <= '0;
      timeout <= 1'b0;
    end else if (aborting) begin
      idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx     <= '0;
            iter    <= '0;
            timeout <= 1'b0;
          end
        end
        INIT: begin
          idx     <= '0;
          iter    <= '0;
          timeout <= 1'b0;
        end
        ADD: idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        CHECK: begin
          if (iter != ITER_MAX) iter <= iter + 1'b1;
          if (isfinished)              timeout <= 1'b0;
          else if (iter == ITER_LAST)  timeout <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    init_w   = (state == INIT);
    init_x   = (state == INIT);
    load_sel = (state == INIT);
    load_a   = (state == INIT) || (state == WB_ACT);
    mult_en  = (state == MULT);
    acc_clr  = (state == MULT) && (idx == '0);
    acc_en   = (state == ADD);
    busy     = (state != IDLE);
    done     = (state == DONE);
  end

endmodule

// File: tb/tb_iter_controller.sv
// Scoreboard bench for iter_controller: two instances (N_IN=4/MAX_ITER=8 and N_IN=1/MAX_ITER=1)
// driven with randomized runs and checked against a cycle-indexed reference model.
module tb_iter_controller;
  localparam int N_A = 4, M_A = 8, P_A = 2 * N_A + 2;
  localparam int N_B = 1, M_B = 1, P_B = 2 * N_B + 2;

  typedef struct {
    int k;
    bit to;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic rst_a, start_a, isf_a, abort_a;
  logic init_w_a, init_x_a, load_sel_a, load_a_a, acc_clr_a, mult_en_a, acc_en_a;
  logic busy_a, timeout_a, done_a;
  logic [1:0] idx_a;
  logic [3:0] iter_a;

  logic rst_b, start_b, isf_b, abort_b;
  logic init_w_b, init_x_b, load_sel_b, load_a_b, acc_clr_b, mult_en_b, acc_en_b;
  logic busy_b, timeout_b, done_b;
  logic [0:0] idx_b;
  logic [0:0] iter_b;

  iter_controller #(.N_IN(N_A), .MAX_ITER(M_A)) dut_a (
    .clk(clk), .rst(rst_a), .start(start_a), .isfinished(isf_a), .abort(abort_a),
    .init_w(init_w_a), .init_x(init_x_a), .load_sel(load_sel_a), .load_a(load_a_a),
    .acc_clr(acc_clr_a), .mult_en(mult_en_a), .acc_en(acc_en_a), .idx(idx_a),
    .iter(iter_a), .busy(busy_a), .timeout(timeout_a), .done(done_a)
  );

  iter_controller #(.N_IN(N_B), .MAX_ITER(M_B)) dut_b (
    .clk(clk), .rst(rst_b), .start(start_b), .isfinished(isf_b), .abort(abort_b),
    .init_w(init_w_b), .init_x(init_x_b), .load_sel(load_sel_b), .load_a(load_a_b),
    .acc_clr(acc_clr_b), .mult_en(mult_en_b), .acc_en(acc_en_b), .idx(idx_b),
    .iter(iter_b), .busy(busy_b), .timeout(timeout_b), .done(done_b)
  );

  // {init_w,init_x,load_sel,load_a,acc_clr,mult_en,acc_en,busy,done,timeout,idx[3:0],iter[4:0]}
  logic [18:0] act_a, act_b;
  assign act_a = {init_w_a, init_x_a, load_sel_a, load_a_a, acc_clr_a, mult_en_a, acc_en_a,
                  busy_a, done_a, timeout_a, 4'(idx_a), 5'(iter_a)};
  assign act_b = {init_w_b, init_x_b, load_sel_b, load_a_b, acc_clr_b, mult_en_b, acc_en_b,
                  busy_b, done_b, timeout_b, 4'(idx_b), 5'(iter_b)};

  exp_t q_a[$];
  exp_t q_b[$];
  int   ecyc_a = -1;
  int   ecyc_b = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Run outcome: converge at iteration conv if within budget, otherwise exhaust the budget.
  function automatic void model(input int conv, input int maxit, output int k, output bit to);
    if (conv >= 1 && conv <= maxit) begin k = conv; to = 1'b0; end
    else begin k = maxit; to = 1'b1; end
  endfunction

  // Expected outputs at cycle c (0 = first MULT) of a run that finishes after k iterations.
  function automatic logic [18:0] exp_outs(input int n, input int k, input bit to, input int c);
    int p, pos, ix, it;
    logic [9:0] f;
    p = 2 * n + 2;
    f = '0;
    f[2] = 1'b1;
    if (c < k * p) begin
      pos  = c % p;
      f[6] = (pos == 2 * n);
      f[5] = (pos == 0);
      f[4] = (pos < 2 * n) && (pos % 2 == 0);
      f[3] = (pos < 2 * n) && (pos % 2 == 1);
      ix   = (pos < 2 * n) ? pos / 2 : 0;
      it   = c / p;
    end else begin
      f[1] = 1'b1;
      f[0] = to;
      ix   = 0;
      it   = k;
    end
    return {f, 4'(ix), 5'(it)};
  endfunction

  int   mk_a, mk_b;
  bit   mt_a, mt_b;
  exp_t me_a, me_b;

  always @(negedge clk) begin
    if (ecyc_a >= 0) begin
      if (q_a.size() > 0) begin mk_a = q_a[0].k; mt_a = q_a[0].to; end
      else begin mk_a = 1 << 20; mt_a = 1'b0; end
      chk("cycle_a", 32'(act_a), 32'(exp_outs(N_A, mk_a, mt_a, ecyc_a)));
    end
    if (done_a === 1'b1) begin
      if (q_a.size() == 0) chk("unexpected_done_a", 32'(done_a), 32'd0);
      else begin
        me_a = q_a.pop_front();
        chk("done_cycle_a", 32'(ecyc_a), 32'(me_a.k * P_A));
      end
    end
  end

  always @(negedge clk) begin
    if (ecyc_b >= 0) begin
      if (q_b.size() > 0) begin mk_b = q_b[0].k; mt_b = q_b[0].to; end
      else begin mk_b = 1 << 20; mt_b = 1'b0; end
      chk("cycle_b", 32'(act_b), 32'(exp_outs(N_B, mk_b, mt_b, ecyc_b)));
    end
    if (done_b === 1'b1) begin
      if (q_b.size() == 0) chk("unexpected_done_b", 32'(done_b), 32'd0);
      else begin
        me_b = q_b.pop_front();
        chk("done_cycle_b", 32'(ecyc_b), 32'(me_b.k * P_B));
      end
    end
  end

  // abort_at / rst_at: cycle index at which to abort or reset (-1 = none).
  task automatic run_a(input int conv, input int hold, input int abort_at, input int rst_at);
    int k, last;
    bit to;
    logic [18:0] idle_exp;
    model(conv, M_A, k, to);
    if (abort_at < 0 && rst_at < 0) q_a.push_back('{k, to});
    @(negedge clk) start_a = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("init_a", 32'(act_a), 32'({10'b1111000100, 4'd0, 5'd0}));
    end
    @(negedge clk) start_a = 1'b0;
    last = (abort_at >= 0) ? abort_at : (rst_at >= 0) ? rst_at : k * P_A;
    for (int c = 0; c <= last; c++) begin
      @(posedge clk); #1;
      ecyc_a  = c;
      isf_a   = (c % P_A == P_A - 1) ? (c / P_A + 1 == conv) : 1'($urandom);
      start_a = (c < k * P_A) ? 1'($urandom) : 1'b0;
      abort_a = (c == abort_at);
      rst_a   = (c != rst_at);
    end
    @(posedge clk); #1;
    ecyc_a = -1; start_a = 1'b0; abort_a = 1'b0; rst_a = 1'b1; isf_a = 1'b0;
    if (rst_at >= 0)        idle_exp = '0;
    else if (abort_at >= 0) idle_exp = {10'b0, 4'd0, 5'(abort_at / P_A)};
    else                    idle_exp = {9'b0, to, 4'd0, 5'(k)};
    chk("idle_a", 32'(act_a), 32'(idle_exp));
    @(posedge clk); #1;
    chk("idle_hold_a", 32'(act_a), 32'(idle_exp));
  endtask

  task automatic run_b(input int conv);
    int k;
    bit to;
    model(conv, M_B, k, to);
    q_b.push_back('{k, to});
    @(negedge clk) start_b = 1'b1;
    @(posedge clk); #1;
    chk("init_b", 32'(act_b), 32'({10'b1111000100, 4'd0, 5'd0}));
    @(negedge clk) start_b = 1'b0;
    for (int c = 0; c <= k * P_B; c++) begin
      @(posedge clk); #1;
      ecyc_b = c;
      isf_b  = (c % P_B == P_B - 1) ? (c / P_B + 1 == conv) : 1'($urandom);
    end
    @(posedge clk); #1;
    ecyc_b = -1; isf_b = 1'b0;
    chk("idle_b", 32'(act_b), 32'({9'b0, to, 4'd0, 5'(k)}));
  endtask

  initial begin
    rst_a = 1'b0; start_a = 1'b0; isf_a = 1'b0; abort_a = 1'b0;
    rst_b = 1'b0; start_b = 1'b0; isf_b = 1'b0; abort_b = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("reset_a", 32'(act_a), 32'd0);
      chk("reset_b", 32'(act_b), 32'd0);
    end
    @(negedge clk) begin rst_a = 1'b1; rst_b = 1'b1; end

    run_a(1, 3, -1, -1);
    run_a(3, 1, -1, -1);
    run_a(0, 2, -1, -1);
    run_a(8, 1, -1, -1);
    run_a(0, 1, P_A + 5, -1);
    run_a(2, 2, -1, -1);
    run_a(0, 1, -1, 8);
    run_a(1, 1, -1, -1);
    for (int r = 0; r < 6; r++) run_a(int'($urandom_range(0, 10)), int'($urandom_range(1, 3)), -1, -1);

    run_b(0);
    run_b(1);

    chk("queue_a_empty", 32'(q_a.size()), 32'd0);
    chk("queue_b_empty", 32'(q_b.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
